// File: rtl/lcd_cmd_engine_pkg.sv
// Shared types and constants for the LCD command engine: FSM states, HD44780
// command codes and a helper that picks the long post-command wait.
package lcd_cmd_engine_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StEnHi,
        StHold,
        StExec
    } lcd_state_t;

    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT = 8'h03;

    // Clear/home instructions need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return !rs && (b == CMD_CLEAR || b == CMD_HOME || b == CMD_HOME_ALT);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_cmd_engine_if.sv
// Request channel into the LCD command engine: {rs, byte} over valid/ready.
interface lcd_cmd_engine_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_rs;
    logic [7:0] in_data;

    modport master (output in_valid, output in_rs, output in_data, input in_ready);
    modport slave  (input in_valid, input in_rs, input in_data, output in_ready);
endinterface

// File: rtl/lcd_cmd_engine_sync_fifo.sv
// Single-clock request FIFO with occupancy count and synchronous flush.
// Flush wins over a same-cycle push; pointers wrap modulo DEPTH (power of two).
module lcd_cmd_engine_sync_fifo #(
    parameter int unsigned W     = 9,
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    input  logic [W-1:0]            wdata_i,
    output logic [W-1:0]            rdata_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/lcd_cmd_engine.sv
// HD44780-style write engine: buffers {rs, byte} requests and strobes them onto the
// LCD bus in 8- or 4-bit mode, with all bus timing from cycle counters on sysclk.
module lcd_cmd_engine
    import lcd_cmd_engine_pkg::*;
#(
    parameter int unsigned BUS_W        = 8,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned SETUP_CYC    = 4,
    parameter int unsigned EN_HIGH_CYC  = 12,
    parameter int unsigned HOLD_CYC     = 4,
    parameter int unsigned EXEC_CYC     = 2000,
    parameter int unsigned CLR_EXEC_CYC = 80000
) (
    input  logic                         sysclk,
    input  logic                         reset,
    lcd_cmd_engine_if.slave              req,
    input  logic                         flush,
    output logic                         RSout,
    output logic                         RWout,
    output logic [BUS_W-1:0]             dataOut,
    output logic                         enable,
    output logic                         busy,
    output logic                         dataDone,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int unsigned MaxCyc = max_u(max_u(max_u(SETUP_CYC, EN_HIGH_CYC),
                                                 max_u(HOLD_CYC, EXEC_CYC)), CLR_EXEC_CYC);
    localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

    lcd_state_t        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              rs_q, rs_d;
    logic [7:0]        byte_q, byte_d;
    logic [BUS_W-1:0]  data_q, data_d;
    logic              nib_q, nib_d;
    logic              en_q;
    logic              pop;
    logic [8:0]        head;
    logic              fifo_full, fifo_empty;

    lcd_cmd_engine_sync_fifo #(
        .W     (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (sysclk),
        .rst_ni  (reset),
        .push_i  (req.in_valid),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i ({req.in_rs, req.in_data}),
        .rdata_o (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign req.in_ready = !fifo_full;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        byte_d  = byte_q;
        data_d  = data_q;
        nib_d   = nib_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    rs_d    = head[8];
                    byte_d  = head[7:0];
                    // High nibble first in 4-bit mode; the whole byte in 8-bit mode.
                    data_d  = head[7 -: BUS_W];
                    nib_d   = 1'b0;
                    cnt_d   = CntW'(SETUP_CYC - 1);
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    cnt_d   = CntW'(EN_HIGH_CYC - 1);
                    state_d = StEnHi;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StEnHi: begin
                if (cnt_q == '0) begin
                    cnt_d   = CntW'(HOLD_CYC - 1);
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHold: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (BUS_W == 4 && !nib_q) begin
                    nib_d   = 1'b1;
                    data_d  = byte_q[BUS_W-1:0];
                    cnt_d   = CntW'(SETUP_CYC - 1);
                    state_d = StSetup;
                end else begin
                    cnt_d   = is_long_cmd(rs_q, byte_q) ? CntW'(CLR_EXEC_CYC - 1)
                                                        : CntW'(EXEC_CYC - 1);
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            byte_q  <= '0;
            data_q  <= '0;
            nib_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            byte_q  <= byte_d;
            data_q  <= data_d;
            nib_q   <= nib_d;
            // Registered so the strobe is glitch-free on the pin.
            en_q    <= (state_d == StEnHi);
        end
    end

    assign RSout    = rs_q;
    assign RWout    = 1'b0;
    assign dataOut  = data_q;
    assign enable   = en_q;
    assign busy     = (state_q != StIdle);
    assign dataDone = (state_q == StExec) && (cnt_q == '0);

endmodule

// File: tb/tb_lcd_cmd_engine.sv
// Bench for lcd_cmd_engine: an 8-bit and a nibble-mode instance, with E-pulse and
// dataDone timing predicted per transaction from the pushes and bus timing rules.
module tb_lcd_cmd_engine;

    localparam int S     = 4;
    localparam int EH    = 12;
    localparam int H     = 4;
    localparam int EX    = 40;
    localparam int CLR   = 300;
    localparam int DEPTH = 16;
    localparam int BEAT  = S + EH + H;

    typedef struct { int rise; int fall; logic rs; logic [7:0] d; } pulse_t;
    typedef struct { logic rs; logic [7:0] d; int k; } push_t;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    logic flush8 = 1'b0;
    logic flush4 = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;

    logic       rs8, rw8, en8, bsy8, dd8;
    logic [7:0] dat8;
    logic [4:0] cnt8;
    logic       rs4, rw4, en4, bsy4, dd4;
    logic [3:0] dat4;
    logic [4:0] cnt4;

    pulse_t gp8[$], gp4[$], exp_p[$];
    int     gd8[$], gd4[$], exp_d[$];
    push_t  pushes[$];
    logic   en8_prev = 1'b0;
    logic   en4_prev = 1'b0;

    lcd_cmd_engine_if req8 ();
    lcd_cmd_engine_if req4 ();

    lcd_cmd_engine #(
        .BUS_W(8), .FIFO_DEPTH(DEPTH), .SETUP_CYC(S), .EN_HIGH_CYC(EH),
        .HOLD_CYC(H), .EXEC_CYC(EX), .CLR_EXEC_CYC(CLR)
    ) dut8 (
        .sysclk(sysclk), .reset(reset), .req(req8), .flush(flush8), .RSout(rs8),
        .RWout(rw8), .dataOut(dat8), .enable(en8), .busy(bsy8), .dataDone(dd8),
        .fifo_count(cnt8)
    );

    lcd_cmd_engine #(
        .BUS_W(4), .FIFO_DEPTH(DEPTH), .SETUP_CYC(S), .EN_HIGH_CYC(EH),
        .HOLD_CYC(H), .EXEC_CYC(EX), .CLR_EXEC_CYC(CLR)
    ) dut4 (
        .sysclk(sysclk), .reset(reset), .req(req4), .flush(flush4), .RSout(rs4),
        .RWout(rw4), .dataOut(dat4), .enable(en4), .busy(bsy4), .dataDone(dd4),
        .fifo_count(cnt4)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    // Bus monitors: cyc at a negedge is the index of the most recent rising edge.
    always @(negedge sysclk) begin
        pulse_t p;
        if (en8 && !en8_prev) gp8.push_back('{rise: cyc, fall: -1, rs: rs8, d: dat8});
        if (!en8 && en8_prev && gp8.size() > 0) begin
            p = gp8.pop_back();
            p.fall = cyc;
            gp8.push_back(p);
        end
        if (dd8) gd8.push_back(cyc);
        en8_prev = en8;
    end

    always @(negedge sysclk) begin
        pulse_t p;
        if (en4 && !en4_prev) gp4.push_back('{rise: cyc, fall: -1, rs: rs4, d: {4'h0, dat4}});
        if (!en4 && en4_prev && gp4.size() > 0) begin
            p = gp4.pop_back();
            p.fall = cyc;
            gp4.push_back(p);
        end
        if (dd4) gd4.push_back(cyc);
        en4_prev = en4;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got time=%0t want finish before 900000", $time);
        $fatal(1);
    end

    // Call at a negedge; returns at the negedge after the push edge.
    task automatic drive8(input logic r, input logic [7:0] v);
        req8.in_valid = 1'b1;
        req8.in_rs    = r;
        req8.in_data  = v;
        if (req8.in_ready) pushes.push_back('{rs: r, d: v, k: cyc + 1});
        @(negedge sysclk);
        req8.in_valid = 1'b0;
    endtask

    task automatic drive4(input logic r, input logic [7:0] v);
        req4.in_valid = 1'b1;
        req4.in_rs    = r;
        req4.in_data  = v;
        if (req4.in_ready) pushes.push_back('{rs: r, d: v, k: cyc + 1});
        @(negedge sysclk);
        req4.in_valid = 1'b0;
    endtask

    // Transaction-level prediction: each byte is popped one edge after it is queued or
    // one edge after the engine returns to idle, then spends beats*BEAT cycles on the
    // bus and a command-dependent wait.
    task automatic model_trace(input int bw);
        int earliest;
        int pop_e;
        int x;
        int nb;
        int w;
        pulse_t p;
        earliest = 0;
        exp_p.delete();
        exp_d.delete();
        nb = (bw == 4) ? 2 : 1;
        foreach (pushes[i]) begin
            pop_e = (pushes[i].k + 1 > earliest) ? pushes[i].k + 1 : earliest;
            for (int b = 0; b < nb; b++) begin
                p.rise = pop_e + S + b * BEAT;
                p.fall = p.rise + EH;
                p.rs   = pushes[i].rs;
                if (bw == 4) p.d = (b == 0) ? {4'h0, pushes[i].d[7:4]} : {4'h0, pushes[i].d[3:0]};
                else         p.d = pushes[i].d;
                exp_p.push_back(p);
            end
            x = pop_e + nb * BEAT;
            w = (!pushes[i].rs && (pushes[i].d inside {8'h01, 8'h02, 8'h03})) ? CLR : EX;
            exp_d.push_back(x + w - 1);
            earliest = x + w + 1;
        end
    endtask

    task automatic wait_model_end();
        int endc;
        endc = (exp_d.size() > 0) ? exp_d[exp_d.size() - 1] + 3 : cyc + 10;
        while (cyc < endc) @(negedge sysclk);
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        repeat (3) @(negedge sysclk);
        checks++;
        if ({en8, rs8, rw8, bsy8, dd8, dat8, cnt8} !== 18'b0)
            $display("FAIL reset_out8 got %b want 0", {en8, rs8, rw8, bsy8, dd8, dat8, cnt8});
        else passes++;
        checks++;
        if ({en4, rs4, rw4, bsy4, dd4, dat4, cnt4} !== 14'b0)
            $display("FAIL reset_out4 got %b want 0", {en4, rs4, rw4, bsy4, dd4, dat4, cnt4});
        else passes++;
        checks++;
        if ({req8.in_ready, req4.in_ready} !== 2'b11)
            $display("FAIL reset_ready got %b want 11", {req8.in_ready, req4.in_ready});
        else passes++;
        reset = 1'b1;
        @(negedge sysclk);
        checks++;
        if ({bsy8, bsy4, cnt8, cnt4, req8.in_ready} !== 13'b1)
            $display("FAIL reset_release got %b want 1", {bsy8, bsy4, cnt8, cnt4, req8.in_ready});
        else passes++;
    endtask

    task automatic test_single8();
        pushes.delete(); gp8.delete(); gd8.delete();
        @(negedge sysclk);
        drive8(1'b1, 8'hA5);
        checks++;
        if (cnt8 !== 5'd1 || bsy8 !== 1'b0)
            $display("FAIL single_push got cnt=%0d busy=%b want cnt=1 busy=0", cnt8, bsy8);
        else passes++;
        @(negedge sysclk);
        checks++;
        if (cnt8 !== 5'd0 || bsy8 !== 1'b1 || rs8 !== 1'b1 || dat8 !== 8'hA5 || en8 !== 1'b0)
            $display("FAIL single_pop got cnt=%0d busy=%b rs=%b d=%h e=%b want 0 1 1 a5 0",
                     cnt8, bsy8, rs8, dat8, en8);
        else passes++;
        model_trace(8);
        wait_model_end();
        checks++;
        if (gp8.size() != exp_p.size())
            $display("FAIL single_npulse got %0d want %0d", gp8.size(), exp_p.size());
        else passes++;
        for (int i = 0; i < exp_p.size() && i < gp8.size(); i++) begin
            checks++;
            if (gp8[i].rise != exp_p[i].rise || gp8[i].fall != exp_p[i].fall ||
                gp8[i].rs !== exp_p[i].rs || gp8[i].d !== exp_p[i].d)
                $display("FAIL single_pulse%0d got %0d/%0d/%b/%h want %0d/%0d/%b/%h", i,
                         gp8[i].rise, gp8[i].fall, gp8[i].rs, gp8[i].d,
                         exp_p[i].rise, exp_p[i].fall, exp_p[i].rs, exp_p[i].d);
            else passes++;
        end
        checks++;
        if (gd8.size() != 1 || gd8[0] != exp_d[0])
            $display("FAIL single_done got n=%0d want n=1 at %0d", gd8.size(), exp_d[0]);
        else passes++;
    endtask

    task automatic test_nibble();
        pushes.delete(); gp4.delete(); gd4.delete();
        @(negedge sysclk);
        drive4(1'b0, 8'h38);
        repeat (3) begin
            repeat ($urandom_range(0, 30)) @(negedge sysclk);
            drive4(1'($urandom_range(0, 1)), 8'($urandom));
        end
        model_trace(4);
        wait_model_end();
        checks++;
        if (gp4.size() != exp_p.size())
            $display("FAIL nibble_npulse got %0d want %0d", gp4.size(), exp_p.size());
        else passes++;
        for (int i = 0; i < exp_p.size() && i < gp4.size(); i++) begin
            checks++;
            if (gp4[i].rise != exp_p[i].rise || gp4[i].fall != exp_p[i].fall ||
                gp4[i].rs !== exp_p[i].rs || gp4[i].d !== exp_p[i].d)
                $display("FAIL nibble_pulse%0d got %0d/%0d/%b/%h want %0d/%0d/%b/%h", i,
                         gp4[i].rise, gp4[i].fall, gp4[i].rs, gp4[i].d,
                         exp_p[i].rise, exp_p[i].fall, exp_p[i].rs, exp_p[i].d);
            else passes++;
        end
        checks++;
        if (gd4.size() != exp_d.size())
            $display("FAIL nibble_ndone got %0d want %0d", gd4.size(), exp_d.size());
        else passes++;
        for (int i = 0; i < exp_d.size() && i < gd4.size(); i++) begin
            checks++;
            if (gd4[i] != exp_d[i]) $display("FAIL nibble_done%0d got %0d want %0d", i, gd4[i], exp_d[i]);
            else passes++;
        end
    endtask

    task automatic test_long_cmd();
        int n;
        pushes.delete(); gp8.delete(); gd8.delete();
        @(negedge sysclk);
        drive8(1'b0, 8'h01);
        n = 0;
        while (gd8.size() < 1 && n < CLR + 200) begin @(negedge sysclk); n++; end
        @(negedge sysclk);
        drive8(1'b0, 8'h0C);
        n = 0;
        while (gd8.size() < 2 && n < EX + 200) begin @(negedge sysclk); n++; end
        checks++;
        if (gp8.size() != 2 || gd8.size() != 2)
            $display("FAIL long_counts got pulses=%0d dones=%0d want 2 2", gp8.size(), gd8.size());
        else begin
            passes++;
            checks++;
            if (gd8[0] - (gp8[0].fall + H) + 1 != CLR)
                $display("FAIL long_clear_exec got %0d want %0d", gd8[0] - (gp8[0].fall + H) + 1, CLR);
            else passes++;
            checks++;
            if (gd8[1] - (gp8[1].fall + H) + 1 != EX)
                $display("FAIL long_norm_exec got %0d want %0d", gd8[1] - (gp8[1].fall + H) + 1, EX);
            else passes++;
        end
        repeat (3) @(negedge sysclk);
    endtask

    task automatic test_fill();
        pushes.delete(); gp8.delete(); gd8.delete();
        @(negedge sysclk);
        drive8(1'b1, 8'hA0);
        for (int i = 0; i < 20; i++) drive8(1'($urandom_range(0, 1)), 8'($urandom));
        checks++;
        if (pushes.size() - 1 != DEPTH)
            $display("FAIL fill_accepted got %0d want %0d", pushes.size() - 1, DEPTH);
        else passes++;
        checks++;
        if (cnt8 !== 5'(DEPTH) || req8.in_ready !== 1'b0)
            $display("FAIL fill_full got cnt=%0d ready=%b want cnt=%0d ready=0",
                     cnt8, req8.in_ready, DEPTH);
        else passes++;
        model_trace(8);
        wait_model_end();
        checks++;
        if (gp8.size() != exp_p.size())
            $display("FAIL fill_npulse got %0d want %0d", gp8.size(), exp_p.size());
        else passes++;
        for (int i = 0; i < exp_p.size() && i < gp8.size(); i++) begin
            checks++;
            if (gp8[i].rise != exp_p[i].rise || gp8[i].rs !== exp_p[i].rs || gp8[i].d !== exp_p[i].d)
                $display("FAIL fill_pulse%0d got %0d/%b/%h want %0d/%b/%h", i,
                         gp8[i].rise, gp8[i].rs, gp8[i].d, exp_p[i].rise, exp_p[i].rs, exp_p[i].d);
            else passes++;
        end
        checks++;
        if (gd8.size() != exp_d.size() || gd8[gd8.size() - 1] != exp_d[exp_d.size() - 1])
            $display("FAIL fill_done got n=%0d want n=%0d", gd8.size(), exp_d.size());
        else passes++;
    endtask

    task automatic test_random8();
        logic       r;
        logic [7:0] v;
        pushes.delete(); gp8.delete(); gd8.delete();
        @(negedge sysclk);
        repeat (12) begin
            repeat ($urandom_range(0, 60)) @(negedge sysclk);
            r = 1'($urandom_range(0, 1));
            v = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            drive8(r, v);
        end
        model_trace(8);
        wait_model_end();
        checks++;
        if (gp8.size() != exp_p.size())
            $display("FAIL rand_npulse got %0d want %0d", gp8.size(), exp_p.size());
        else passes++;
        for (int i = 0; i < exp_p.size() && i < gp8.size(); i++) begin
            checks++;
            if (gp8[i].rise != exp_p[i].rise || gp8[i].fall != exp_p[i].fall ||
                gp8[i].rs !== exp_p[i].rs || gp8[i].d !== exp_p[i].d)
                $display("FAIL rand_pulse%0d got %0d/%0d/%b/%h want %0d/%0d/%b/%h", i,
                         gp8[i].rise, gp8[i].fall, gp8[i].rs, gp8[i].d,
                         exp_p[i].rise, exp_p[i].fall, exp_p[i].rs, exp_p[i].d);
            else passes++;
        end
        checks++;
        if (gd8.size() != exp_d.size())
            $display("FAIL rand_ndone got %0d want %0d", gd8.size(), exp_d.size());
        else passes++;
        for (int i = 0; i < exp_d.size() && i < gd8.size(); i++) begin
            checks++;
            if (gd8[i] != exp_d[i]) $display("FAIL rand_done%0d got %0d want %0d", i, gd8[i], exp_d[i]);
            else passes++;
        end
    endtask

    task automatic test_flush();
        pushes.delete(); gp8.delete(); gd8.delete();
        @(negedge sysclk);
        drive8(1'b1, 8'h11);
        repeat (5) drive8(1'b1, 8'($urandom));
        checks++;
        if (cnt8 !== 5'd5) $display("FAIL flush_queued got %0d want 5", cnt8);
        else passes++;
        flush8 = 1'b1;
        req8.in_valid = 1'b1;
        req8.in_rs = 1'b1;
        req8.in_data = 8'hEE;
        @(negedge sysclk);
        flush8 = 1'b0;
        req8.in_valid = 1'b0;
        checks++;
        if (cnt8 !== 5'd0 || req8.in_ready !== 1'b1)
            $display("FAIL flush_clear got cnt=%0d ready=%b want 0 1", cnt8, req8.in_ready);
        else passes++;
        repeat (BEAT + EX + 60) @(negedge sysclk);
        checks++;
        if (gp8.size() != 1 || gd8.size() != 1 || bsy8 !== 1'b0)
            $display("FAIL flush_after got pulses=%0d dones=%0d busy=%b want 1 1 0",
                     gp8.size(), gd8.size(), bsy8);
        else passes++;
        checks++;
        if (gp8.size() < 1 || gp8[0].d !== 8'h11 || gp8[0].fall - gp8[0].rise != EH)
            $display("FAIL flush_inflight got n=%0d want d=11 width=%0d", gp8.size(), EH);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int n;
        pushes.delete(); gp8.delete(); gd8.delete();
        @(negedge sysclk);
        drive8(1'b1, 8'h5A);
        drive8(1'b0, 8'h81);
        n = 0;
        while (en8 !== 1'b1 && n < 100) begin @(negedge sysclk); n++; end
        checks++;
        if (en8 !== 1'b1) $display("FAIL rstmid_reach_en got e=%b want 1", en8);
        else passes++;
        @(posedge sysclk);
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({en8, rs8, dat8} !== 10'b0 || cnt8 !== 5'd0 || bsy8 !== 1'b0)
            $display("FAIL rstmid_async got e=%b rs=%b d=%h cnt=%0d busy=%b want all 0",
                     en8, rs8, dat8, cnt8, bsy8);
        else passes++;
        @(negedge sysclk);
        @(negedge sysclk);
        reset = 1'b1;
        gp8.delete(); gd8.delete();
        repeat (CLR + 50) @(negedge sysclk);
        checks++;
        if (gp8.size() != 0 || gd8.size() != 0)
            $display("FAIL rstmid_quiet got pulses=%0d dones=%0d want 0 0", gp8.size(), gd8.size());
        else passes++;
        drive8(1'b1, 8'h3C);
        repeat (BEAT + EX + 5) @(negedge sysclk);
        checks++;
        if (gp8.size() != 1 || gd8.size() != 1 || gp8[0].d !== 8'h3C ||
            gp8[0].fall - gp8[0].rise != EH)
            $display("FAIL rstmid_resume got pulses=%0d dones=%0d want 1 1 d=3c",
                     gp8.size(), gd8.size());
        else passes++;
    endtask

    initial begin
        req8.in_valid = 1'b0; req8.in_rs = 1'b0; req8.in_data = 8'h00;
        req4.in_valid = 1'b0; req4.in_rs = 1'b0; req4.in_data = 8'h00;
        test_reset();
        test_single8();
        test_nibble();
        test_long_cmd();
        test_fill();
        test_random8();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
